// File: rtl/axi_pkg.sv
// Shared AXI definitions: RRESP encodings and the packed R-beat width helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Width of one packed R beat {id, user, resp, last, data}.
    function automatic int r_beat_width(input int id_w, input int data_w, input int user_w);
        return id_w + user_w + 2 + 1 + data_w;
    endfunction

endpackage

// File: rtl/axi_buf_fifo_core.sv
// Generic WIDTH x DEPTH circular FIFO with push/pop, full/empty flags and occupancy count.
// Latency: a pushed word is visible on rd_data the cycle after the push.
// Backpressure: push is ignored when full and pop is ignored when empty; callers gate on the flags.
module axi_buf_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage array is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_r_chan_fifo.sv
// AXI4 R-channel buffer: BUFF_DEPTH-entry FIFO with optional fall-through, occupancy, burst count and sticky error.
// Latency: 1 cycle slave accept to master valid (registered), 0 cycles when FALL_THROUGH=1 and empty.
// Backpressure: slave_ready_o drops only when full; it is never a combinational function of master_ready_i.
module axi_r_chan_fifo
    import axi_pkg::*;
#(
    parameter int ID_WIDTH     = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int USER_WIDTH   = 10,
    parameter int BUFF_DEPTH   = 4,
    parameter int FALL_THROUGH = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          test_en_i,
    input  logic                          slave_valid_i,
    input  logic [DATA_WIDTH-1:0]         slave_data_i,
    input  logic [1:0]                    slave_resp_i,
    input  logic [USER_WIDTH-1:0]         slave_user_i,
    input  logic [ID_WIDTH-1:0]           slave_id_i,
    input  logic                          slave_last_i,
    output logic                          slave_ready_o,
    output logic                          master_valid_o,
    output logic [DATA_WIDTH-1:0]         master_data_o,
    output logic [1:0]                    master_resp_o,
    output logic [USER_WIDTH-1:0]         master_user_o,
    output logic [ID_WIDTH-1:0]           master_id_o,
    output logic                          master_last_o,
    input  logic                          master_ready_i,
    output logic [$clog2(BUFF_DEPTH):0]   usage_o,
    output logic [$clog2(BUFF_DEPTH):0]   bursts_o,
    output logic                          err_o
);

    localparam int  BEAT_W = r_beat_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);
    localparam int  CW     = $clog2(BUFF_DEPTH) + 1;
    localparam bit  FT     = (FALL_THROUGH != 0);

    logic              rdy_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] out_beat;
    logic              push_acc;
    logic              bypass_vld;
    logic              bypass;
    logic              pop;
    logic              fifo_push;
    logic              fifo_pop;

    logic [ID_WIDTH-1:0]   st_id;
    logic [USER_WIDTH-1:0] st_user;
    logic [1:0]            st_resp;
    logic                  st_last;
    logic [DATA_WIDTH-1:0] st_data;

    // Test mode is reserved and has no functional effect.
    logic unused_test_en;
    assign unused_test_en = test_en_i;

    assign in_beat = {slave_id_i, slave_user_i, slave_resp_i, slave_last_i, slave_data_i};
    assign {st_id, st_user, st_resp, st_last, st_data} = out_beat;

    assign slave_ready_o = rdy_en & ~fifo_full;
    assign push_acc      = slave_valid_i & slave_ready_o;

    // An empty fall-through buffer presents the incoming beat directly.
    assign bypass_vld = FT & fifo_empty & push_acc;
    assign bypass     = bypass_vld & master_ready_i;

    assign master_valid_o = ~fifo_empty | bypass_vld;
    assign master_data_o  = bypass_vld ? slave_data_i : st_data;
    assign master_resp_o  = bypass_vld ? slave_resp_i : st_resp;
    assign master_user_o  = bypass_vld ? slave_user_i : st_user;
    assign master_id_o    = bypass_vld ? slave_id_i   : st_id;
    assign master_last_o  = bypass_vld ? slave_last_i : st_last;

    assign pop       = master_valid_o & master_ready_i;
    assign fifo_push = push_acc & ~bypass;
    assign fifo_pop  = pop & ~fifo_empty;
    assign usage_o   = fifo_count;

    axi_buf_fifo_core #(
        .WIDTH (BEAT_W),
        .DEPTH (BUFF_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (fifo_push),
        .wr_data (in_beat),
        .pop     (fifo_pop),
        .rd_data (out_beat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Hold off the slave for one edge after reset release so ready never rises with reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdy_en <= 1'b0;
        else         rdy_en <= 1'b1;
    end

    // Count complete bursts held in storage; bypassed beats never enter it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bursts_o <= '0;
        end else begin
            case ({fifo_push & slave_last_i, fifo_pop & st_last})
                2'b10:   bursts_o <= bursts_o + CW'(1);
                2'b01:   bursts_o <= bursts_o - CW'(1);
                default: bursts_o <= bursts_o;
            endcase
        end
    end

    // Sticky error on any accepted SLVERR/DECERR beat, stored or bypassed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                         err_o <= 1'b0;
        else if (push_acc && slave_resp_i[1]) err_o <= 1'b1;
    end

endmodule

// File: tb/tb_axi_r_chan_fifo.sv
// Directed bench for axi_r_chan_fifo: registered instance plus a fall-through instance.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 3 units after posedge.
// Backpressure: exercised by holding master ready low until the buffer fills.
module tb_axi_r_chan_fifo;

    localparam int IDW = 16;
    localparam int DW  = 32;
    localparam int UW  = 10;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst_ni;

    // registered-mode instance
    logic           s_vld, s_rdy, s_last, m_vld, m_last, m_rdy, err;
    logic [DW-1:0]  s_dat, m_dat;
    logic [1:0]     s_resp, m_resp;
    logic [UW-1:0]  s_user, m_user;
    logic [IDW-1:0] s_id, m_id;
    logic [CW-1:0]  usage, bursts;

    // fall-through instance
    logic           f_s_vld, f_s_rdy, f_m_vld, f_m_last, f_m_rdy, f_err;
    logic [DW-1:0]  f_s_dat, f_m_dat;
    logic [1:0]     f_m_resp;
    logic [UW-1:0]  f_m_user;
    logic [IDW-1:0] f_m_id;
    logic [CW-1:0]  f_usage, f_bursts;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_r_chan_fifo #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .BUFF_DEPTH(4), .FALL_THROUGH(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .test_en_i(1'b0),
        .slave_valid_i(s_vld), .slave_data_i(s_dat), .slave_resp_i(s_resp), .slave_user_i(s_user),
        .slave_id_i(s_id), .slave_last_i(s_last), .slave_ready_o(s_rdy),
        .master_valid_o(m_vld), .master_data_o(m_dat), .master_resp_o(m_resp), .master_user_o(m_user),
        .master_id_o(m_id), .master_last_o(m_last), .master_ready_i(m_rdy),
        .usage_o(usage), .bursts_o(bursts), .err_o(err)
    );

    axi_r_chan_fifo #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .BUFF_DEPTH(4), .FALL_THROUGH(1)) u_dut_ft (
        .clk_i(clk), .rst_ni(rst_ni), .test_en_i(1'b0),
        .slave_valid_i(f_s_vld), .slave_data_i(f_s_dat), .slave_resp_i(2'b00), .slave_user_i('0),
        .slave_id_i('0), .slave_last_i(1'b0), .slave_ready_o(f_s_rdy),
        .master_valid_o(f_m_vld), .master_data_o(f_m_dat), .master_resp_o(f_m_resp), .master_user_o(f_m_user),
        .master_id_o(f_m_id), .master_last_o(f_m_last), .master_ready_i(f_m_rdy),
        .usage_o(f_usage), .bursts_o(f_bursts), .err_o(f_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        s_vld = 1'b1; s_dat = '0; s_resp = 2'b00; s_user = '0; s_id = '0; s_last = 1'b0; m_rdy = 1'b0;
        f_s_vld = 1'b0; f_s_dat = '0; f_m_rdy = 1'b0;

        // reset release with slave valid held high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", s_rdy, 0);
        chk("rst_mvalid", m_vld, 0);
        rst_ni = 1'b1;
        #2;
        chk("rel_ready_pre_edge", s_rdy, 0);
        chk("rel_usage", usage, 0);
        chk("rel_mvalid", m_vld, 0);
        @(posedge clk); #3;
        chk("rel_ready_after_edge", s_rdy, 1);
        chk("rel_usage_after_edge", usage, 0);
        s_vld = 1'b0;

        // fall-through: bypass with ready high, then store with ready low
        @(posedge clk); #1;
        f_s_vld = 1'b1; f_s_dat = 32'hA5; f_m_rdy = 1'b1;
        #2;
        chk("ft_bypass_valid", f_m_vld, 1);
        chk("ft_bypass_data", f_m_dat, 32'hA5);
        chk("ft_bypass_usage", f_usage, 0);
        @(posedge clk); #1;
        f_s_dat = 32'h5A; f_m_rdy = 1'b0;
        #2;
        chk("ft_after_bypass_usage", f_usage, 0);
        chk("ft_hold_valid", f_m_vld, 1);
        chk("ft_hold_data", f_m_dat, 32'h5A);
        @(posedge clk); #1;
        f_s_vld = 1'b0;
        #2;
        chk("ft_stored_usage", f_usage, 1);
        chk("ft_stored_valid", f_m_vld, 1);
        chk("ft_stored_data", f_m_dat, 32'h5A);
        f_m_rdy = 1'b1;
        @(posedge clk); #3;
        chk("ft_drained_usage", f_usage, 0);
        chk("ft_drained_valid", f_m_vld, 0);

        // fill to full with master stalled
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            s_vld = 1'b1; s_dat = 32'((i + 1) * 32'h11); s_last = (i == 3);
        end
        @(posedge clk); #1;
        s_vld = 1'b0; s_last = 1'b0;
        #2;
        chk("full_usage", usage, 4);
        chk("full_bursts", bursts, 1);
        chk("full_ready", s_rdy, 0);
        chk("full_mvalid", m_vld, 1);
        m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", m_dat, 64'((i + 1) * 32'h11));
            chk("drain_last", m_last, (i == 3) ? 64'd1 : 64'd0);
            @(posedge clk); #3;
            if (i == 0) begin
                chk("pop_at_full_ready", s_rdy, 1);
                chk("pop_at_full_usage", usage, 3);
            end
        end
        chk("drain_usage", usage, 0);
        chk("drain_bursts", bursts, 0);
        chk("drain_mvalid", m_vld, 0);

        // streaming at full rate
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            s_vld = 1'b1; s_dat = 32'h100 + 32'(i);
            #2;
            if (i > 0) begin
                chk("stream_valid", m_vld, 1);
                chk("stream_data", m_dat, 64'(32'h100 + 32'(i - 1)));
                chk("stream_usage", usage, 1);
            end
        end
        @(posedge clk); #1;
        s_vld = 1'b0;
        #2;
        chk("stream_tail_data", m_dat, 32'h10F);
        @(posedge clk); #3;
        chk("stream_end_usage", usage, 0);

        // sticky error from a DECERR beat
        m_rdy = 1'b0;
        @(posedge clk); #1;
        s_vld = 1'b1; s_dat = 32'hDEC; s_resp = 2'b11;
        #2;
        chk("err_before_push", err, 0);
        @(posedge clk); #1;
        s_dat = 32'h0C0; s_resp = 2'b00;
        #2;
        chk("err_set", err, 1);
        chk("err_beat_resp", m_resp, 2'b11);
        chk("err_beat_data", m_dat, 32'hDEC);
        @(posedge clk); #1;
        s_vld = 1'b0;
        #2;
        chk("err_sticky", err, 1);
        chk("err_stall_resp", m_resp, 2'b11);
        chk("err_usage", usage, 2);
        m_rdy = 1'b1;
        @(posedge clk); #3;
        chk("ok_beat_resp", m_resp, 2'b00);
        chk("ok_beat_data", m_dat, 32'h0C0);
        chk("err_still_sticky", err, 1);
        @(posedge clk); #3;
        chk("err_drain_usage", usage, 0);
        m_rdy = 1'b0;

        // asynchronous reset with three beats stored
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            s_vld = 1'b1; s_dat = 32'h700 + 32'(i); s_last = (i == 2);
        end
        @(posedge clk); #1;
        s_vld = 1'b0; s_last = 1'b0;
        #2;
        chk("prerst_usage", usage, 3);
        chk("prerst_bursts", bursts, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_mvalid", m_vld, 0);
        chk("arst_usage", usage, 0);
        chk("arst_bursts", bursts, 0);
        chk("arst_err", err, 0);
        chk("arst_ready", s_rdy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
